// File: rtl/branch_predict_resolve_unit_if.sv
// Fetch/EX signal bundle for branch_predict_resolve_unit.
// Defining BP_PERF_CNT_EN adds the perf_branches/perf_mispredicts counters.
interface branch_predict_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic            res_valid;
    logic            res_B;
    logic [2:0]      res_funct3;
    logic            res_Z;
    logic            res_C;
    logic            res_V;
    logic            res_S;
    logic [PC_W-1:0] res_pc;
    logic            res_pred_taken;
    logic            branch;
    logic            mispredict;
    logic            mispredict_taken;
`ifdef BP_PERF_CNT_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    modport master (
        output pred_pc, res_valid, res_B, res_funct3, res_Z, res_C, res_V, res_S,
               res_pc, res_pred_taken,
        input  pred_taken, branch, mispredict, mispredict_taken
`ifdef BP_PERF_CNT_EN
        , input perf_branches, perf_mispredicts
`endif
    );

    modport slave (
        input  pred_pc, res_valid, res_B, res_funct3, res_Z, res_C, res_V, res_S,
               res_pc, res_pred_taken,
        output pred_taken, branch, mispredict, mispredict_taken
`ifdef BP_PERF_CNT_EN
        , output perf_branches, perf_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// Saturating-counter branch predictor with EX-stage condition resolve and mispredict pulse.
// Defining BP_PERF_CNT_EN adds 32-bit branch and mispredict event counters.
module branch_predict_resolve_unit #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    branch_predict_resolve_unit_if.slave bus
);
    localparam int unsigned      DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

    logic [CNT_W-1:0] r_tbl [DEPTH];
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_legal;
    logic             w_cond;
    logic             w_qual;
    logic             w_branch;
    logic             w_mis;
    logic             r_mis;
    logic             r_mis_taken;
    logic             w_unused_pc;

    assign w_pred_idx  = bus.pred_pc[IDX_W+1:2];
    assign w_res_idx   = bus.res_pc[IDX_W+1:2];
    assign w_unused_pc = ^{bus.pred_pc[1:0], bus.pred_pc[PC_W-1:IDX_W+2],
                           bus.res_pc[1:0],  bus.res_pc[PC_W-1:IDX_W+2]};

    // Prediction reads the registered table directly; a same-cycle update shows next cycle.
    assign bus.pred_taken = r_tbl[w_pred_idx][CNT_W-1];

    always_comb begin
        w_legal = 1'b1;
        w_cond  = 1'b0;
        case (bus.res_funct3)
            3'b000:  w_cond = bus.res_Z;
            3'b001:  w_cond = !bus.res_Z;
            3'b100:  w_cond = bus.res_S != bus.res_V;
            3'b101:  w_cond = bus.res_S == bus.res_V;
            3'b110:  w_cond = !bus.res_C;
            3'b111:  w_cond = bus.res_C;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_qual     = bus.res_valid & bus.res_B & w_legal;
    assign w_branch   = w_qual & w_cond;
    assign w_mis      = w_qual & (w_branch != bus.res_pred_taken);
    assign bus.branch = w_branch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= CNT_INIT;
            end
        end else if (w_qual) begin
            if (w_branch) begin
                if (r_tbl[w_res_idx] != CNT_MAX) begin
                    r_tbl[w_res_idx] <= r_tbl[w_res_idx] + CNT_W'(1);
                end
            end else if (r_tbl[w_res_idx] != '0) begin
                r_tbl[w_res_idx] <= r_tbl[w_res_idx] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis       <= 1'b0;
            r_mis_taken <= 1'b0;
        end else begin
            r_mis       <= w_mis;
            r_mis_taken <= w_mis & w_branch;
        end
    end

    assign bus.mispredict       = r_mis;
    assign bus.mispredict_taken = r_mis_taken;

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_qual) r_perf_br  <= r_perf_br + 32'd1;
            if (w_mis)  r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign bus.perf_branches    = r_perf_br;
    assign bus.perf_mispredicts = r_perf_mis;
`endif
endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench for branch_predict_resolve_unit (IDX_W=6, CNT_W=2, PC_W=32).
module tb_branch_predict_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_predict_resolve_unit_if #(.PC_W(32)) bus ();

    branch_predict_resolve_unit #(
        .IDX_W(6),
        .CNT_W(2),
        .PC_W (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       v;
        logic       b;
        logic [2:0] f3;
        logic       z;
        logic       c;
        logic       vf;
        logic       s;
        logic       pt;
        logic       exp_br;
        logic       exp_mis;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic v, input logic b, input logic [2:0] f3,
                       input logic z, input logic c, input logic vf, input logic s,
                       input logic [31:0] pc, input logic pt);
        bus.res_valid      = v;
        bus.res_B          = b;
        bus.res_funct3     = f3;
        bus.res_Z          = z;
        bus.res_C          = c;
        bus.res_V          = vf;
        bus.res_S          = s;
        bus.res_pc         = pc;
        bus.res_pred_taken = pt;
    endtask

    task automatic idle();
        res(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_all_weak(input string name);
        for (int i = 0; i < 64; i++) begin
            bus.pred_pc = 32'(i) << 2;
            #1;
            check(name, 32'(bus.pred_taken), 32'd0);
        end
    endtask

    initial begin
        //          v     b     f3    z     c     vf    s     pt    br    mis
        vt[0]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle();
        bus.pred_pc = '0;

        // Reset state
        repeat (2) tick();
        check("rst_mis", 32'(bus.mispredict), 32'd0);
        check("rst_mis_taken", 32'(bus.mispredict_taken), 32'd0);
        rst = 1'b1;
        tick();
        check_all_weak("rst_pred");

        // Increment and saturate at 11 on PC 0x100 (index 0)
        bus.pred_pc = 32'h100;
        res(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0);
        #1;
        check("sat_pred0", 32'(bus.pred_taken), 32'd0);
        check("sat_branch", 32'(bus.branch), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_pred", 32'(bus.pred_taken), 32'd1);
            check("sat_mis", 32'(bus.mispredict), 32'd1);
            check("sat_mis_taken", 32'(bus.mispredict_taken), 32'd1);
        end
        // Two not-taken resolves predicted taken: 11 -> 10 -> 01
        res(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1);
        tick();
        check("dec_mis", 32'(bus.mispredict), 32'd1);
        check("dec_mis_taken", 32'(bus.mispredict_taken), 32'd0);
        check("dec_pred_10", 32'(bus.pred_taken), 32'd1);
        tick();
        check("dec_pred_01", 32'(bus.pred_taken), 32'd0);
        // Two more not-taken predicted not-taken: 01 -> 00 -> 00, no mispredict
        res(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0);
        tick();
        check("dec_nomis", 32'(bus.mispredict), 32'd0);
        tick();
        check("dec_floor_pred", 32'(bus.pred_taken), 32'd0);
        // One taken from 00 gives 01, still not-taken
        res(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0);
        tick();
        check("floor_up_pred", 32'(bus.pred_taken), 32'd0);
        idle();
        tick();
        check("idle_mis", 32'(bus.mispredict), 32'd0);
        check("idle_mis_taken", 32'(bus.mispredict_taken), 32'd0);

        // funct3 / flag sweep
        for (int i = 0; i < 17; i++) begin
            res(vt[i].v, vt[i].b, vt[i].f3, vt[i].z, vt[i].c, vt[i].vf, vt[i].s,
                32'h300 + 32'(i * 4), vt[i].pt);
            #1;
            check($sformatf("vec%0d_branch", i), 32'(bus.branch), 32'(vt[i].exp_br));
            tick();
            check($sformatf("vec%0d_mis", i), 32'(bus.mispredict), 32'(vt[i].exp_mis));
            check($sformatf("vec%0d_mis_taken", i), 32'(bus.mispredict_taken),
                  32'(vt[i].exp_mis & vt[i].exp_br));
        end
        idle();
        tick();

        // Same-cycle predict/update on PC 0x40
        bus.pred_pc = 32'h40;
        res(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0);
        #1;
        check("same_old", 32'(bus.pred_taken), 32'd0);
        tick();
        idle();
        #1;
        check("same_new", 32'(bus.pred_taken), 32'd1);

        // Illegal funct3 leaves a trained counter (PC 0x80 -> 10) untouched
        bus.pred_pc = 32'h80;
        res(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1);
        tick();
        check("ill_trained", 32'(bus.pred_taken), 32'd1);
        res(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1);
        tick();
        res(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1);
        tick();
        check("ill_nomis", 32'(bus.mispredict), 32'd0);
        check("ill_pred_kept", 32'(bus.pred_taken), 32'd1);
        idle();

        // Reset during back-to-back mispredicts on PC 0xC0
        res(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC0, 1'b0);
        tick();
        check("b2b_mis1", 32'(bus.mispredict), 32'd1);
        tick();
        check("b2b_mis2", 32'(bus.mispredict), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_mis", 32'(bus.mispredict), 32'd0);
        check("midrst_mis_taken", 32'(bus.mispredict_taken), 32'd0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        check("postrst_mis", 32'(bus.mispredict), 32'd0);
        check_all_weak("postrst_pred");

`ifdef BP_PERF_CNT_EN
        check("perf_br_rst", bus.perf_branches, 32'd0);
        check("perf_mis_rst", bus.perf_mispredicts, 32'd0);
        for (int i = 0; i < 10; i++) begin
            res(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, (i < 3) ? 1'b0 : 1'b1);
            tick();
        end
        idle();
        tick();
        check("perf_br", bus.perf_branches, 32'd10);
        check("perf_mis", bus.perf_mispredicts, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Parametrised successor to the combinational branch decision logic.
- Holds a table of N saturating counters, indexed by PC bits, that supplies a taken/not-taken prediction at fetch.
- Resolves conditional branches in EX from funct3 and the ALU flags (Z, C, V, S), trains the table, and issues a registered mispredict/redirect pulse back to fetch.

Parameters:
- IDX_W, 6: table index width; table depth = 2**IDX_W entries.
- CNT_W, 2: counter width per entry, legal range 1..4.
- PC_W, 32: PC width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pred_pc  in  PC_W  fetch-stage PC.
- pred_taken  out  1  combinational prediction for pred_pc.
- res_valid  in  1  EX-stage instruction is valid.
- res_B  in  1  branch control signal from the control unit.
- res_funct3  in  3  instruction[14:12].
- res_Z, res_C, res_V, res_S  in  1 each  ALU zero, carry (1 = no borrow), overflow and negative flags.
- res_pc  in  PC_W  PC of the EX-stage branch.
- res_pred_taken  in  1  prediction carried down the pipe with this branch.
- branch  out  1  combinational actual decision, same cycle as the inputs.
- mispredict  out  1  registered one-cycle pulse.
- mispredict_taken  out  1  registered: correct direction on a mispredict.

Behaviour:
- Table index = PC[IDX_W+1:2] for both pred_pc and res_pc; bits [1:0] are ignored.
- pred_taken = MSB of the indexed counter. Pure combinational read, no bypass of a same-cycle update.
- branch is 0 unless res_valid=1 and res_B=1. When both are 1, it decodes funct3 as:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: S!=V
  - 101 BGE: S==V
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010, 011: 0
- A qualified resolve requires res_valid & res_B and a legal funct3. On the rising edge:
  - If branch=1, the indexed counter increments and saturates at 2**CNT_W-1.
  - If branch=0, the counter decrements and saturates at 0.
- Illegal funct3 with res_B=1: no counter update and no mispredict.
- mispredict is registered one cycle after a qualified resolve when branch != res_pred_taken; mispredict_taken = branch in that cycle.
- When mispredict=0, mispredict_taken is held at 0.
- Otherwise mispredict=0. Back-to-back resolves produce back-to-back pulses, with no internal stall.
- Same index predicted and updated in one cycle: prediction uses the pre-update value; the update takes effect next cycle.
- Resolves on distinct indices in consecutive cycles are independent. Aliasing PCs share a counter by design.
- Reset, asserted at any time including mid-update:
  - Every counter is set to 2**(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2; 0 for CNT_W=1).
  - mispredict=0 and mispredict_taken=0.
  - Any in-flight mispredict pulse is dropped.
- Outputs are valid from the first edge after rst deasserts.

Optional Feature:
- BP_PERF_CNT_EN: when defined, adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
  - perf_branches increments on each qualified resolve.
  - perf_mispredicts increments on the edge that sets mispredict.
  - Both wrap at 2**32, reset to 0 and are readable combinationally.
- When undefined, neither port nor its logic exists.

Test Plan:
- Reset then read all 64 indices (IDX_W=6, CNT_W=2) -> pred_taken=0 everywhere; mispredict=0.
- Resolve res_pc=0x100, BEQ, Z=1, res_pred_taken=0 three times -> counter 01→10→11→11 (saturates); pred_taken for pred_pc=0x100 goes 1 after the first update; mispredict pulses on the first resolve and, since res_pred_taken stays 0, on every later one, with mispredict_taken=1.
- Full funct3 sweep with Z/C/V/S combos (e.g. BLT S=1,V=0 -> branch=1; BGEU C=0 -> branch=0; funct3=010 -> branch=0 and no counter change).
- Same-cycle pred_pc=res_pc=0x40 with a taken resolve -> pred_taken shows the old value that cycle and the new value the next cycle.
- Assert rst low for one cycle during back-to-back mispredicting resolves -> mispredict drops immediately and all counters return to 01.
- With BP_PERF_CNT_EN: 10 resolves of which 3 mispredict -> perf_branches=10, perf_mispredicts=3; preload near 0xFFFFFFFF and check the wrap to 0.
